pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the PC/IF/ID/EX/MEM/WB pipeline.
- Merges the decode-stage load-use stall request, EX multi-cycle operation requests (mul/div) and exception/branch flush requests.
- Drives one per-stage stall vector, a one-cycle flush pulse and the redirect PC.
- Owns a small FSM and cycle counter so EX multi-cycle ops hold the front of the pipe for an exact, bounded time.

Parameters:
- CNT_W, 6, width of the multi-cycle length/counter (max op length 2^CNT_W-1 cycles)
- RESET_PC, 32'h1c000000, value of new_pc_o out of reset

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
- id_stallreq_i  input  1  load-use hazard from decode, combinational, level
- ex_mc_start_i  input  1  one-cycle pulse: EX begins a multi-cycle op
- ex_mc_len_i  input  CNT_W  total cycles of that op, valid with ex_mc_start_i
- ex_mc_done_i  input  1  EX early completion (e.g. divider zero-skip)
- flush_req_i  input  1  exception/redirect request, level, one cycle
- flush_pc_i  input  32  redirect target, valid with flush_req_i
- stall_o  output  6  stall per stage: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
- flush_o  output  1  registered flush pulse to all pipe registers
- new_pc_o  output  32  registered redirect PC, valid when flush_o=1
- mc_busy_o  output  1  FSM in MC state

Behaviour:
- FSM states:
  - IDLE
  - MC (EX multi-cycle in progress)
  - FLUSH (exactly one cycle per request)
- Reset (rst==0 at clk edge): state=IDLE, counter=0, flush_o=0, new_pc_o=RESET_PC. While rst==0, stall_o=6'b000000 and mc_busy_o=0. Reset mid-MC or mid-FLUSH aborts immediately, with no pending flush.
- Priority at each edge: flush_req_i > MC handling > idle.
- flush_req_i=1 in any state: next state FLUSH, new_pc_o<=flush_pc_i, flush_o<=1 next cycle. Any MC op is aborted and the counter is cleared.
- FLUSH: stall_o=0, flush_o=1. Next state IDLE unless flush_req_i=1 again, which re-latches the PC and stays in FLUSH.
- IDLE with ex_mc_start_i=1:
  - ex_mc_len_i>=2: go to MC, counter<=ex_mc_len_i-2.
  - ex_mc_len_i of 0 or 1: no stall, stay IDLE.
- MC:
  - stall_o=6'b001111, mc_busy_o=1.
  - Each cycle the counter decrements.
  - Exit to IDLE at the edge where counter==0 or ex_mc_done_i=1.
  - Total stall = ex_mc_len_i-1 cycles.
  - ex_mc_start_i in MC is ignored (EX is stalled, so this is illegal); assertion in simulation.
- stall_o is combinational from state plus id_stallreq_i:
  - FLUSH or reset: 6'b000000.
  - MC: 6'b001111, regardless of id_stallreq_i.
  - IDLE and id_stallreq_i=1: 6'b000111 (bubble into EX).
  - Otherwise: 6'b000000.
- flush_o and new_pc_o are registered, so latency is 1 cycle from flush_req_i. new_pc_o holds its value between flushes.
- Counter arithmetic is unsigned CNT_W and never wraps, since exit occurs at 0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - Adds outputs stall_cyc_o[31:0] and flush_cnt_o[31:0].
  - stall_cyc_o counts cycles with stall_o!=0; flush_cnt_o counts FLUSH-state cycles.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst==0.
- When undefined: the ports and logic are absent and there is no other behavioural change.

Decomposition:
- Shared Defines.v gets:
  - `StallBus 5:0
  - stage bit indices (`STG_PC..`STG_WB)
  - stall patterns `STALL_NONE/`STALL_ID/`STALL_EX
  - FSM encodings `PC_IDLE/`PC_MC/`PC_FLUSH
  - `RstnEnable 1'b0
- One sub-module, pipe_mc_cnt: loadable down-counter with load, dec and zero outputs, instantiated once.

Test Plan:
- Reset: hold rst=0 for 3 cycles during MC -> stall_o=0, flush_o=0, new_pc_o=32'h1c000000, mc_busy_o=0 on release.
- Load-use: id_stallreq_i=1 for 2 cycles in IDLE -> stall_o=6'b000111 for exactly those 2 cycles, then 0.
- Multi-cycle: ex_mc_start_i pulse with len=5 -> stall_o=6'b001111 for 4 cycles, then 0. len=1 -> no stall.
- Early done: len=34, ex_mc_done_i at the 3rd MC cycle -> MC exits at that edge, 3 stall cycles total.
- Flush during MC: flush_req_i=1 with flush_pc_i=32'h1c000400 at MC cycle 2 -> next cycle flush_o=1, new_pc_o=32'h1c000400, stall_o=0, then IDLE.
- Back-to-back flush: flush_req_i on 2 consecutive cycles with PCs A, B -> flush_o high 2 cycles, new_pc_o=A then B. With PIPE_CTRL_PERF_EN, flush_cnt_o=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall bus layout, stall patterns and FSM encodings for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  // Stall the named stage and everything in front of it; later stages drain.
  localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_BUS_W-1:0] STALL_EX   = 6'b001111;

  localparam logic RSTN_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_MC    = 2'd1,
    PC_FLUSH = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_mc_cnt.sv
// rtl/pipe_mc_cnt.sv - loadable down-counter timing EX multi-cycle operations
module pipe_mc_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Decrement stops at zero so the value never wraps.
  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_stallreq_i,
  input  logic                   ex_mc_start_i,
  input  logic [CNT_W-1:0]       ex_mc_len_i,
  input  logic                   ex_mc_done_i,
  input  logic                   flush_req_i,
  input  logic [31:0]            flush_pc_i,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]            stall_cyc_o,
  output logic [31:0]            flush_cnt_o,
`endif
  output logic [STALL_BUS_W-1:0] stall_o,
  output logic                   flush_o,
  output logic [31:0]            new_pc_o,
  output logic                   mc_busy_o
);

  pc_state_e state, state_nxt;
  logic      cnt_zero;
  logic      cnt_clr;
  logic      cnt_load;
  logic      cnt_dec;
  logic      mc_long;

  assign mc_long = (ex_mc_len_i >= CNT_W'(2));

  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE) begin
      state    <= PC_IDLE;
      flush_o  <= 1'b0;
      new_pc_o <= RESET_PC;
    end else begin
      state   <= state_nxt;
      flush_o <= flush_req_i;
      if (flush_req_i) begin
        new_pc_o <= flush_pc_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (flush_req_i) begin
      state_nxt = PC_FLUSH;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        PC_IDLE: begin
          if (ex_mc_start_i && mc_long) begin
            state_nxt = PC_MC;
            cnt_load  = 1'b1;
          end
        end
        PC_MC: begin
          if (cnt_zero || ex_mc_done_i) begin
            state_nxt = PC_IDLE;
            cnt_clr   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        PC_FLUSH: state_nxt = PC_IDLE;
        default:  state_nxt = PC_IDLE;
      endcase
    end
  end

  // Stall is combinational so a load-use bubble takes effect in the same cycle.
  always_comb begin
    stall_o   = STALL_NONE;
    mc_busy_o = 1'b0;
    if (rst != RSTN_ENABLE) begin
      case (state)
        PC_MC: begin
          stall_o   = STALL_EX;
          mc_busy_o = 1'b1;
        end
        PC_IDLE:  stall_o = id_stallreq_i ? STALL_ID : STALL_NONE;
        default:  stall_o = STALL_NONE;
      endcase
    end
  end

  pipe_mc_cnt #(
    .CNT_W(CNT_W)
  ) u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (ex_mc_len_i - CNT_W'(2)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE) begin
      stall_cyc_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o != STALL_NONE && stall_cyc_o != '1) begin
        stall_cyc_o <= stall_cyc_o + 32'd1;
      end
      if (state == PC_FLUSH && flush_cnt_o != '1) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

  // EX is frozen during MC, so a new start there indicates an upstream bug.
  mc_start_in_mc : assert property (@(posedge clk) disable iff (rst == RSTN_ENABLE)
                                    (state == PC_MC) |-> !ex_mc_start_i);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam logic [5:0]  S_NONE = 6'b000000;
  localparam logic [5:0]  S_ID   = 6'b000111;
  localparam logic [5:0]  S_EX   = 6'b001111;
  localparam logic [31:0] R_PC   = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_stallreq_i = 1'b0;
  logic        ex_mc_start_i = 1'b0;
  logic [5:0]  ex_mc_len_i = '0;
  logic        ex_mc_done_i = 1'b0;
  logic        flush_req_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_busy_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc_o;
  logic [31:0] flush_cnt_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_stallreq_i (id_stallreq_i),
    .ex_mc_start_i (ex_mc_start_i),
    .ex_mc_len_i   (ex_mc_len_i),
    .ex_mc_done_i  (ex_mc_done_i),
    .flush_req_i   (flush_req_i),
    .flush_pc_i    (flush_pc_i),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cyc_o   (stall_cyc_o),
    .flush_cnt_o   (flush_cnt_o),
`endif
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .mc_busy_o     (mc_busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    ex_mc_start_i = 1'b1;
    ex_mc_len_i = 6'd10;
    tick();
    ex_mc_start_i = 1'b0;
    total_cnt++;
    if (mc_busy_o !== 1'b1 || stall_o !== S_EX)
      $display("FAIL reset_pre_mc busy=%b stall=%b required busy=1 stall=%b", mc_busy_o, stall_o, S_EX);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (stall_o !== S_NONE || mc_busy_o !== 1'b0)
      $display("FAIL reset_during stall=%b busy=%b required 000000/0", stall_o, mc_busy_o);
    else pass_cnt++;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (stall_o !== S_NONE || mc_busy_o !== 1'b0 || flush_o !== 1'b0 || new_pc_o !== R_PC)
      $display("FAIL reset_release stall=%b busy=%b flush=%b pc=%h required 000000/0/0/%h",
               stall_o, mc_busy_o, flush_o, new_pc_o, R_PC);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mc_busy_o !== 1'b0)
      $display("FAIL reset_no_resume busy=%b required 0", mc_busy_o);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      id_stallreq_i = (i < 2);
      #1;
      total_cnt++;
      if (stall_o !== ((i < 2) ? S_ID : S_NONE))
        $display("FAIL load_use[%0d] stall=%b required %b", i, stall_o, (i < 2) ? S_ID : S_NONE);
      else pass_cnt++;
      tick();
    end
    id_stallreq_i = 1'b0;
  endtask

  task automatic run_mc(input logic [5:0] len, input int stall_cycles, input string name);
    ex_mc_start_i = 1'b1;
    ex_mc_len_i = len;
    tick();
    ex_mc_start_i = 1'b0;
    for (int i = 0; i < stall_cycles + 2; i++) begin
      id_stallreq_i = (i == 0);
      #1;
      total_cnt++;
      if (stall_o !== ((i < stall_cycles) ? S_EX : ((i == 0) ? S_ID : S_NONE)))
        $display("FAIL %s[%0d] stall=%b required %b", name, i, stall_o,
                 (i < stall_cycles) ? S_EX : ((i == 0) ? S_ID : S_NONE));
      else pass_cnt++;
      tick();
    end
    id_stallreq_i = 1'b0;
  endtask

  task automatic test_multi_cycle();
    run_mc(6'd5, 4, "mc_len5");
    run_mc(6'd1, 0, "mc_len1");
    run_mc(6'd2, 1, "mc_len2");
    run_mc(6'd0, 0, "mc_len0");
  endtask

  task automatic test_early_done();
    ex_mc_start_i = 1'b1;
    ex_mc_len_i = 6'd34;
    tick();
    ex_mc_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_mc_done_i = (i == 2);
      #1;
      total_cnt++;
      if (stall_o !== S_EX)
        $display("FAIL early_done_mc[%0d] stall=%b required %b", i, stall_o, S_EX);
      else pass_cnt++;
      tick();
    end
    ex_mc_done_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (stall_o !== S_NONE || mc_busy_o !== 1'b0)
        $display("FAIL early_done_exit[%0d] stall=%b busy=%b required 000000/0", i, stall_o, mc_busy_o);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_flush_mc();
    ex_mc_start_i = 1'b1;
    ex_mc_len_i = 6'd10;
    tick();
    ex_mc_start_i = 1'b0;
    tick();
    flush_req_i = 1'b1;
    flush_pc_i = 32'h1c000400;
    tick();
    flush_req_i = 1'b0;
    id_stallreq_i = 1'b1;
    #1;
    total_cnt++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'h1c000400 || stall_o !== S_NONE || mc_busy_o !== 1'b0)
      $display("FAIL flush_mc flush=%b pc=%h stall=%b busy=%b required 1/1c000400/000000/0",
               flush_o, new_pc_o, stall_o, mc_busy_o);
    else pass_cnt++;
    tick();
    id_stallreq_i = 1'b0;
    #1;
    total_cnt++;
    if (flush_o !== 1'b0 || new_pc_o !== 32'h1c000400 || stall_o !== S_NONE || mc_busy_o !== 1'b0)
      $display("FAIL flush_mc_after flush=%b pc=%h stall=%b busy=%b required 0/1c000400/000000/0",
               flush_o, new_pc_o, stall_o, mc_busy_o);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    flush_req_i = 1'b1;
    flush_pc_i = 32'h1c000a00;
    tick();
    total_cnt++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'h1c000a00)
      $display("FAIL b2b_first flush=%b pc=%h required 1/1c000a00", flush_o, new_pc_o);
    else pass_cnt++;
    flush_pc_i = 32'h1c000b00;
    tick();
    flush_req_i = 1'b0;
    total_cnt++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'h1c000b00)
      $display("FAIL b2b_second flush=%b pc=%h required 1/1c000b00", flush_o, new_pc_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flush_o !== 1'b0 || new_pc_o !== 32'h1c000b00 || stall_o !== S_NONE)
      $display("FAIL b2b_end flush=%b pc=%h stall=%b required 0/1c000b00/000000", flush_o, new_pc_o, stall_o);
    else pass_cnt++;
`ifdef PIPE_CTRL_PERF_EN
    total_cnt++;
    if (flush_cnt_o !== 32'd2 || stall_cyc_o !== 32'd0)
      $display("FAIL b2b_perf flush_cnt=%0d stall_cyc=%0d required 2/0", flush_cnt_o, stall_cyc_o);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multi_cycle();
    test_early_done();
    test_flush_mc();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
